// File: rtl/line_mem_responder_if.sv
// rtl/line_mem_responder_if.sv - line request bus between a cache controller and the backing memory
//
// Signals:
//    re      cache -> mem   read request
//    we      cache -> mem   write request (wins over re)
//    addr    cache -> mem   line address
//    wdata   cache -> mem   write line
//    rd_data mem -> cache   read line, valid while rdy=1 and held afterwards
//    rdy     mem -> cache   one-cycle completion pulse
//    busy    mem -> cache   a request is outstanding
interface line_mem_responder_if #(
   parameter int ADDR_W = 14,
   parameter int LINE_W = 64
);
   logic              re;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rd_data;
   logic              rdy;
   logic              busy;

   modport master (
      output re, we, addr, wdata,
      input  rd_data, rdy, busy
   );

   modport slave (
      input  re, we, addr, wdata,
      output rd_data, rdy, busy
   );
endinterface

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - unified backing memory with fixed latency and one outstanding request
//
// Ports:
//    clk   system clock, rising edge
//    rst   synchronous active-high reset
//    bus   line request bus (slave side): re/we/addr/wdata in, rd_data/rdy/busy out
//
// Parameters:
//    ADDR_W   line address width (depth 2^ADDR_W lines)
//    LINE_W   line width in bits
//    LATENCY  edges from acceptance to rdy, 1..15
module line_mem_responder #(
   parameter int ADDR_W  = 14,
   parameter int LINE_W  = 64,
   parameter int LATENCY = 4
) (
   input logic                  clk,
   input logic                  rst,
   line_mem_responder_if.slave  bus
);

   localparam int          DEPTH    = 1 << ADDR_W;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          count_q, count_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [LINE_W-1:0]   rd_data_q, rd_data_d;
   logic                rdy_q, rdy_d;
   logic                mem_we;

   // Contents are never cleared; they are undefined until written.
   logic [LINE_W-1:0]   mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         rdy_q     <= rdy_d;
      end
   end

   // A write whose commit edge coincides with reset is aborted, not committed.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[addr_q] <= wdata_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      rdy_d     = 1'b0;
      mem_we    = 1'b0;

      case (state_q)
         IDLE: begin
            // Requests are taken even while rdy is high, allowing back-to-back issue.
            if (bus.we) begin
               state_d = WRITE;
               count_d = CNT_LOAD;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
            end else if (bus.re) begin
               state_d = READ;
               count_d = CNT_LOAD;
               addr_d  = bus.addr;
            end
         end
         READ: begin
            if (count_q != 4'd0) begin
               count_d = count_q - 4'd1;
            end else begin
               rd_data_d = mem[addr_q];
               rdy_d     = 1'b1;
               state_d   = IDLE;
            end
         end
         WRITE: begin
            if (count_q != 4'd0) begin
               count_d = count_q - 4'd1;
            end else begin
               mem_we  = 1'b1;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.rd_data = rd_data_q;
   assign bus.rdy     = rdy_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - bench for line_mem_responder at LATENCY 4 and LATENCY 1
module tb_line_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_v   [2];
   logic        re_v    [2];
   logic        we_v    [2];
   logic [13:0] addr_v  [2];
   logic [63:0] wdata_v [2];

   line_mem_responder_if #(.ADDR_W(14), .LINE_W(64)) b4 ();
   line_mem_responder_if #(.ADDR_W(14), .LINE_W(64)) b1 ();

   logic rst4, rst1;
   assign rst4     = rst_v[0];
   assign rst1     = rst_v[1];
   assign b4.re    = re_v[0];
   assign b4.we    = we_v[0];
   assign b4.addr  = addr_v[0];
   assign b4.wdata = wdata_v[0];
   assign b1.re    = re_v[1];
   assign b1.we    = we_v[1];
   assign b1.addr  = addr_v[1];
   assign b1.wdata = wdata_v[1];

   line_mem_responder #(.ADDR_W(14), .LINE_W(64), .LATENCY(4)) u4 (
      .clk (clk),
      .rst (rst4),
      .bus (b4.slave)
   );

   line_mem_responder #(.ADDR_W(14), .LINE_W(64), .LATENCY(1)) u1 (
      .clk (clk),
      .rst (rst1),
      .bus (b1.slave)
   );

   int cmp_n = 0;
   int err_n = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: each DUT holds at most one pending transaction that completes a fixed
   // number of edges after it was accepted; memory is a sparse map.
   int          lat_p [2] = '{4, 1};
   int          cyc = 0;
   logic [63:0] mem_m [int];
   bit          pend  [2];
   int          due   [2];
   bit          is_wr [2];
   logic [13:0] m_a   [2];
   logic [63:0] m_d   [2];
   logic        m_rdy [2];
   logic        m_busy[2];
   logic [63:0] m_rd  [2];

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst_v[i]) begin
            pend[i] = 0; m_rdy[i] = 0; m_busy[i] = 0; m_rd[i] = 64'h0;
         end else begin
            m_rdy[i] = 0;
            if (pend[i] && cyc == due[i]) begin
               if (is_wr[i]) mem_m[i * 65536 + int'(m_a[i])] = m_d[i];
               else m_rd[i] = mem_m.exists(i * 65536 + int'(m_a[i])) ? mem_m[i * 65536 + int'(m_a[i])] : 64'hx;
               m_rdy[i] = 1; m_busy[i] = 0; pend[i] = 0;
            end else if (!pend[i] && (we_v[i] || re_v[i])) begin
               pend[i] = 1; due[i] = cyc + lat_p[i]; is_wr[i] = we_v[i];
               m_a[i] = addr_v[i]; m_d[i] = wdata_v[i]; m_busy[i] = 1;
            end
         end
      end
   end

   bit chk_en = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_rdy4",  {63'd0, b4.rdy},  {63'd0, m_rdy[0]});
         check("cyc_busy4", {63'd0, b4.busy}, {63'd0, m_busy[0]});
         check("cyc_rd4",   b4.rd_data, m_rd[0]);
         check("cyc_rdy1",  {63'd0, b1.rdy},  {63'd0, m_rdy[1]});
         check("cyc_busy1", {63'd0, b1.busy}, {63'd0, m_busy[1]});
         check("cyc_rd1",   b1.rd_data, m_rd[1]);
      end
   end

   function automatic logic get_rdy(input int i);
      return (i == 0) ? b4.rdy : b1.rdy;
   endfunction

   function automatic logic [63:0] get_rd(input int i);
      return (i == 0) ? b4.rd_data : b1.rd_data;
   endfunction

   // Entered and left at a falling edge; issues one request and waits for its rdy.
   task automatic do_req(input int i, input logic w, input logic r, input logic [13:0] a,
                         input logic [63:0] d, output int acc, output int rcyc,
                         output logic [63:0] rd);
      int t;
      we_v[i] = w; re_v[i] = r; addr_v[i] = a; wdata_v[i] = d;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      we_v[i] = 0; re_v[i] = 0;
      t = 0;
      while (!get_rdy(i) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!get_rdy(i)) check("rdy_timeout", 64'd0, 64'd1);
      rcyc = cyc;
      rd   = get_rd(i);
   endtask

   initial begin
      int a0, r0, a1, r1, pulses, t, last;
      logic [63:0] rd, held;
      for (int i = 0; i < 2; i++) begin
         rst_v[i] = 1; re_v[i] = 0; we_v[i] = 0; addr_v[i] = '0; wdata_v[i] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rdy",  {63'd0, b4.rdy},  64'd0);
      check("reset_busy", {63'd0, b4.busy}, 64'd0);
      check("reset_rd",   b4.rd_data, 64'd0);
      rst_v[0] = 0; rst_v[1] = 0;
      chk_en = 1;

      // Write then read, LATENCY 4
      do_req(0, 1, 0, 14'h0012, 64'h1111_2222_3333_4444, a0, r0, rd);
      check("wr_latency", 64'(r0 - a0), 64'd4);
      do_req(0, 0, 1, 14'h0012, 64'h0, a1, r1, rd);
      check("wr_rd_span", 64'(r1 - a0), 64'd9);
      check("rd_data_12", rd, 64'h1111_2222_3333_4444);

      // Preload
      do_req(0, 1, 0, 14'h3FFF, 64'h77, a0, r0, rd);
      do_req(0, 1, 0, 14'h0020, 64'h5, a0, r0, rd);
      do_req(0, 1, 0, 14'h0001, 64'h0101_0101_0101_0101, a0, r0, rd);
      do_req(0, 1, 0, 14'h0002, 64'h0202_0202_0202_0202, a0, r0, rd);

      // Inputs toggled during a read are ignored
      re_v[0] = 1; addr_v[0] = 14'h0012;
      @(posedge clk);
      @(negedge clk);
      re_v[0] = 0; addr_v[0] = 14'h3FFF; we_v[0] = 1; wdata_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      we_v[0] = 0;
      pulses = 0; held = 64'h0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (b4.rdy) begin pulses++; held = b4.rd_data; end
      end
      check("held_pulses", 64'(pulses), 64'd1);
      check("held_data", held, 64'h1111_2222_3333_4444);

      // re and we together act as a write
      do_req(0, 1, 1, 14'h0100, 64'hDEAD_BEEF_0000_0001, a0, r0, rd);
      check("rw_rd_unchanged", rd, 64'h1111_2222_3333_4444);
      do_req(0, 0, 1, 14'h0100, 64'h0, a0, r0, rd);
      check("rw_readback", rd, 64'hDEAD_BEEF_0000_0001);

      // Reset two edges into a write
      we_v[0] = 1; addr_v[0] = 14'h0020; wdata_v[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      @(posedge clk);
      @(negedge clk);
      we_v[0] = 0;
      @(negedge clk);
      rst_v[0] = 1;
      @(negedge clk);
      check("mid_rst_busy", {63'd0, b4.busy}, 64'd0);
      check("mid_rst_rd",   b4.rd_data, 64'd0);
      check("mid_rst_rdy",  {63'd0, b4.rdy}, 64'd0);
      rst_v[0] = 0;
      repeat (6) @(negedge clk);
      do_req(0, 0, 1, 14'h0020, 64'h0, a0, r0, rd);
      check("aborted_write", rd, 64'h5);
      do_req(0, 0, 1, 14'h3FFF, 64'h0, a0, r0, rd);
      check("no_stray_write", rd, 64'h77);

      // Back-to-back reads with re held high
      re_v[0] = 1; addr_v[0] = 14'h0001;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!b4.rdy && t < 20);
         if (!b4.rdy) check("b2b_timeout", 64'd0, 64'd1);
         check($sformatf("b2b_data%0d", k), b4.rd_data,
               (k % 2 == 0) ? 64'h0101_0101_0101_0101 : 64'h0202_0202_0202_0202);
         if (k > 0) check($sformatf("b2b_gap%0d", k), 64'(cyc - last), 64'd5);
         last = cyc;
         addr_v[0] = (k % 2 == 0) ? 14'h0002 : 14'h0001;
         if (k == 3) re_v[0] = 0;
      end
      repeat (6) @(negedge clk);

      // LATENCY 1 build
      do_req(1, 1, 0, 14'h0012, 64'h1111_2222_3333_4444, a0, r0, rd);
      check("l1_wr_latency", 64'(r0 - a0), 64'd1);
      do_req(1, 0, 1, 14'h0012, 64'h0, a1, r1, rd);
      check("l1_rd_latency", 64'(r1 - a1), 64'd1);
      check("l1_span", 64'(r1 - a0), 64'd3);
      check("l1_rd_data", rd, 64'h1111_2222_3333_4444);
      repeat (3) @(negedge clk);

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Responder end of the 64-bit line request interface that the cache controller drives (re/we/addr/wdata in; rd_data/rdy out).
- Models a unified backing memory with a fixed multi-cycle latency and one outstanding request.
- Serves both the instruction-cache line fills and the data-cache fills and evictions.
- Sits below both caches and is the only storage those caches miss to.

Parameters:
- ADDR_W, 14, line address width; array depth is 2^ADDR_W lines.
- LINE_W, 64, line width in bits (four 16-bit words).
- LATENCY, 4, cycles from request acceptance to rdy; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- re  input  1  read request; sampled only in IDLE.
- we  input  1  write request; sampled only in IDLE; wins over re.
- addr  input  ADDR_W  line address; latched at acceptance.
- wdata  input  LINE_W  write line; latched at acceptance.
- rd_data  output  LINE_W  registered read line; valid while rdy=1 and held afterwards.
- rdy  output  1  registered one-cycle completion pulse for both reads and writes.
- busy  output  1  high while a request is outstanding (READ or WRITE state).

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high: rst sampled high at a rising edge of clk.
- Values after a reset edge: state=IDLE, rdy=0, busy=0, rd_data=0, count=0. The memory array is not cleared.
- Reset mid-operation: the request is aborted with no rdy pulse. An aborted write is not committed.
- FSM states: IDLE, READ, WRITE.
- IDLE: if we=1 at edge n, latch addr/wdata, go to WRITE, load count=LATENCY-1, busy=1. Otherwise, if re=1, latch addr, go to READ with the same count load.
- IDLE with re=we=1: treated as a write only. No read is performed.
- READ/WRITE while count!=0: decrement count each edge. re, we, addr and wdata are ignored.
- READ/WRITE, count reaches 0 (edge n+LATENCY):
  - READ: rd_data <= mem[latched addr].
  - WRITE: mem[latched addr] <= latched wdata; rd_data unchanged.
  - rdy <= 1, busy <= 0, state <= IDLE.
- Timing summary: a request accepted at edge n has rdy high from edge n+LATENCY to edge n+LATENCY+1. Exactly one pulse per request.
- LATENCY=1: rdy follows the acceptance edge by exactly one edge.
- rdy is cleared at the edge after it rises.
- Back-to-back requests: a request may be accepted at edge n+LATENCY+1, i.e. in the IDLE cycle in which rdy is high.
  - The initiator drops re/we in the cycle after it sees rdy.
  - If re/we is still high in the rdy cycle, it is a new request and is accepted.
- Read-after-write to the same line: the read is accepted no earlier than the cycle after the write's rdy, so it returns the new data. No forwarding path is needed.
- rd_data holds its last read value through writes and idle periods. It changes only at read completion or reset.
- Address is used unmodified; there is no wrap or bounds logic, since the full 2^ADDR_W range is addressable.
- Array contents are undefined until written.

Test Plan:
- Write then read: at reset release, we=1, addr=14'h0012, wdata=64'h1111_2222_3333_4444 accepted at edge 1. Expect rdy high from edge 5 to 6 and busy=1 over edges 1-5. Then re=1, addr=14'h0012 accepted at edge 6. Expect rdy at edge 10 and rd_data=64'h1111_2222_3333_4444.
- Held inputs ignored: during a read of addr 14'h0012, toggle addr to 14'h3FFF and pulse we. Expect the data from 14'h0012, exactly one rdy, and no write to 14'h3FFF.
- Simultaneous re=we=1 at addr 14'h0100 with wdata=64'hDEAD_BEEF_0000_0001:
  - Expect one rdy and rd_data unchanged (still the previous value).
  - A following read of 14'h0100 returns 64'hDEAD_BEEF_0000_0001.
- Reset mid-write: write 64'hAAAA_AAAA_AAAA_AAAA to 14'h0020 (previously 64'h5) and assert rst at edge acceptance+2.
  - Expect rdy never pulses, and busy=0 and rd_data=0 after the reset edge.
  - A subsequent read of 14'h0020 returns 64'h5.
- Back-to-back: keep re high continuously with addr alternating 14'h0001/14'h0002 (preloaded). Expect rdy pulses every LATENCY+1=5 cycles with alternating correct data.
- LATENCY=1 build: a read accepted at edge n gives rdy and valid rd_data from edge n+1. Repeat the first scenario and expect the write rdy at edge 2 and the read rdy at edge 4.
